keypad_scanner: RTL and testbench

- Scans the calculator's 4x4 matrix keypad and debounces key presses.
- Enforces the operand/operator entry grammar for each accepted key.
- Emits, per accepted key: the 7-segment code, the press index and the key type.
- Drives the CSseg/pulsacion/tipo inputs of the display-scan block; sits between the board keypad pins and the display/operand-capture logic.

---
 rtl/keypad_scanner_if.sv | 28 ++
 rtl/keypad_scanner.sv | 253 +++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: keypad rows/columns and the accepted-key outputs.
// master = scanner side, slave = board/display side.
interface keypad_scanner_if;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [6:0] CSseg;
    logic [3:0] pulsacion;
    logic       tipo;
    logic       key_valid;

    modport master (
        input  filas,
        output columnas,
        output CSseg,
        output pulsacion,
        output tipo,
        output key_valid
    );

    modport slave (
        output filas,
        input  columnas,
        input  CSseg,
        input  pulsacion,
        input  tipo,
        input  key_valid
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 calculator keypad scanner with press/release debounce and entry grammar.
// Ports: clk1kHz, rst_n (async low); bus.master carries filas in, columnas/CSseg/pulsacion/tipo/key_valid out.
module keypad_scanner #(
    parameter int SCAN_TICKS = 1,
    parameter int DEB_TICKS  = 20
) (
    input  logic              clk1kHz,
    input  logic              rst_n,
    keypad_scanner_if.master  bus
);

    localparam int TW = $clog2(SCAN_TICKS + 2);
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);

    localparam logic [6:0] SEG_NUL = 7'b1111111;

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        WAIT_REL,
        DEB_REL
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      col_q, col_d;
    logic [1:0]      row_q, row_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [3:0]      filas_m_q, filas_s_q;

    logic [6:0]      seg_q, seg_d;
    logic [3:0]      puls_q, puls_d;
    logic            tipo_q, tipo_d;
    logic            done_q, done_d;
    logic            kv_q, kv_d;

    logic            accept;

    // Row synchronizer; idle rows read high through the pull-ups.
    always_ff @(posedge clk1kHz or negedge rst_n) begin
        if (!rst_n) begin
            filas_m_q <= 4'hF;
            filas_s_q <= 4'hF;
        end else begin
            filas_m_q <= bus.filas;
            filas_s_q <= filas_m_q;
        end
    end

    logic [3:0] rows_low;
    logic       one_low;
    logic [1:0] row_idx;
    logic       row_match;
    logic       row_high;

    assign rows_low  = ~filas_s_q;
    // Exactly one row low; two or more is treated as ghosting.
    assign one_low   = (rows_low != 4'd0) &&
                       ((rows_low & (rows_low - 4'd1)) == 4'd0);
    assign row_match = (filas_s_q == ~(4'b0001 << row_q));
    assign row_high  = filas_s_q[row_q];

    always_comb begin
        row_idx = 2'd0;
        case (rows_low)
            4'b0001: row_idx = 2'd0;
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    always_ff @(posedge clk1kHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            tick_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        tick_d  = tick_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            SCAN: begin
                // Column held TICK_LAST+1 cycles so the synchronizer
                // has seen the rows for this column before sampling.
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (one_low) begin
                        row_d   = row_idx;
                        cnt_d   = '0;
                        state_d = DEB_PRESS;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            DEB_PRESS: begin
                if (row_match) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_d   = '0;
                        accept  = 1'b1;
                        state_d = WAIT_REL;
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            WAIT_REL: begin
                if (row_high) begin
                    cnt_d   = '0;
                    state_d = DEB_REL;
                end
            end
            DEB_REL: begin
                if (row_high) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_d   = '0;
                        tick_d  = '0;
                        col_d   = col_q + 2'd1;
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                    end
                end else begin
                    state_d = WAIT_REL;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // Key decode for the latched (row, col).
    logic [6:0] key_seg;
    logic       is_dig, is_op, is_eq, is_clr;

    always_comb begin
        key_seg = SEG_NUL;
        is_dig  = 1'b0;
        is_op   = 1'b0;
        is_eq   = 1'b0;
        is_clr  = 1'b0;
        case ({row_q, col_q})
            4'd0:  begin key_seg = 7'b1001111; is_dig = 1'b1; end
            4'd1:  begin key_seg = 7'b0010010; is_dig = 1'b1; end
            4'd2:  begin key_seg = 7'b0000110; is_dig = 1'b1; end
            4'd3:  begin key_seg = 7'b1101100; is_op  = 1'b1; end
            4'd4:  begin key_seg = 7'b1001100; is_dig = 1'b1; end
            4'd5:  begin key_seg = 7'b0100100; is_dig = 1'b1; end
            4'd6:  begin key_seg = 7'b0100000; is_dig = 1'b1; end
            4'd7:  begin key_seg = 7'b1111110; is_op  = 1'b1; end
            4'd8:  begin key_seg = 7'b0001111; is_dig = 1'b1; end
            4'd9:  begin key_seg = 7'b0000000; is_dig = 1'b1; end
            4'd10: begin key_seg = 7'b0000100; is_dig = 1'b1; end
            4'd11: begin key_seg = 7'b1110110; is_eq  = 1'b1; end
            4'd12: begin key_seg = SEG_NUL;    is_clr = 1'b1; end
            4'd13: begin key_seg = 7'b0000001; is_dig = 1'b1; end
            default: key_seg = SEG_NUL;
        endcase
    end

    logic slot_op, slot_dig;
    logic take_clr, take_op, take_dig, take_eq;

    assign slot_op  = (puls_q == 4'd0) || (puls_q == 4'd4);
    assign slot_dig = (puls_q != 4'd0) && (puls_q != 4'd4) &&
                      (puls_q < 4'd8);

    assign take_clr = accept && is_clr;
    assign take_op  = accept && !done_q && is_op  && slot_op;
    assign take_dig = accept && !done_q && is_dig && slot_dig;
    assign take_eq  = accept && !done_q && is_eq  && (puls_q == 4'd8);

    always_comb begin
        seg_d  = seg_q;
        puls_d = puls_q;
        tipo_d = tipo_q;
        done_d = done_q;
        kv_d   = 1'b0;
        unique case (1'b1)
            take_clr: begin
                seg_d  = SEG_NUL;
                puls_d = 4'd0;
                tipo_d = 1'b0;
                done_d = 1'b0;
                kv_d   = 1'b1;
            end
            take_op: begin
                seg_d  = key_seg;
                puls_d = puls_q + 4'd1;
                tipo_d = 1'b0;
                kv_d   = 1'b1;
            end
            take_dig: begin
                seg_d  = key_seg;
                puls_d = puls_q + 4'd1;
                tipo_d = 1'b1;
                kv_d   = 1'b1;
            end
            take_eq: begin
                seg_d  = key_seg;
                tipo_d = 1'b0;
                done_d = 1'b1;
                kv_d   = 1'b1;
            end
            default: kv_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk1kHz or negedge rst_n) begin
        if (!rst_n) begin
            seg_q  <= SEG_NUL;
            puls_q <= 4'd0;
            tipo_q <= 1'b0;
            done_q <= 1'b0;
            kv_q   <= 1'b0;
        end else begin
            seg_q  <= seg_d;
            puls_q <= puls_d;
            tipo_q <= tipo_d;
            done_q <= done_d;
            kv_q   <= kv_d;
        end
    end

    assign bus.columnas  = ~(4'b0001 << col_q);
    assign bus.CSseg     = seg_q;
    assign bus.pulsacion = puls_q;
    assign bus.tipo      = tipo_q;
    assign bus.key_valid = kv_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad matrix model plus per-feature
// test tasks with inline checks.
module tb_keypad_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner_if bus ();

    keypad_scanner #(
        .SCAN_TICKS(1),
        .DEB_TICKS (20)
    ) dut (
        .clk1kHz(clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // Pressed keys, bit index = row*4 + col.
    logic [15:0] mask = 16'h0;

    always_comb begin
        logic [3:0] f;
        f = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mask[r*4+c] && !bus.columnas[c])
                    f[r] = 1'b0;
        bus.filas = f;
    end

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int doubles = 0;
    int cyc = 0;
    int last_strobe = 0;
    logic prev_kv = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bus.key_valid === 1'b1) begin
            strobes++;
            last_strobe = cyc;
            if (prev_kv) doubles++;
        end
        prev_kv = (bus.key_valid === 1'b1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic tap(input int idx, input int hold, input int rel);
        mask[idx] = 1'b1;
        wait_cyc(hold);
        mask[idx] = 1'b0;
        wait_cyc(rel);
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst_n = 1'b0;
        mask  = 16'h0;
        wait_cyc(3);
        checks++;
        if (bus.columnas !== 4'b1110) begin
            errors++;
            $display("FAIL rst_col got %b exp 1110", bus.columnas);
        end
        checks++;
        if (bus.CSseg !== 7'b1111111) begin
            errors++;
            $display("FAIL rst_seg got %b exp 1111111", bus.CSseg);
        end
        checks++;
        if (bus.pulsacion !== 4'd0) begin
            errors++;
            $display("FAIL rst_puls got %0d exp 0", bus.pulsacion);
        end
        checks++;
        if (bus.tipo !== 1'b0) begin
            errors++;
            $display("FAIL rst_tipo got %b exp 0", bus.tipo);
        end
        checks++;
        if (bus.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_kv got %b exp 0", bus.key_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 15; k++) begin
            exp = ~(4'b0001 << ((k / 3) % 4));
            checks++;
            if (bus.columnas !== exp) begin
                errors++;
                $display("FAIL scan_col k=%0d got %b exp %b",
                         k, bus.columnas, exp);
            end
            wait_cyc(1);
        end
        checks++;
        if (strobes != 0 || bus.pulsacion !== 4'd0) begin
            errors++;
            $display("FAIL idle_out strobes %0d puls %0d exp 0 0",
                     strobes, bus.pulsacion);
        end
    endtask

    task automatic test_single_key();
        int s0, p0, lat;
        s0 = strobes;
        p0 = cyc;
        mask[7] = 1'b1;
        wait_cyc(45);
        lat = last_strobe - p0;
        checks++;
        if (strobes != s0 + 1) begin
            errors++;
            $display("FAIL minus_strobe got %0d exp %0d", strobes - s0, 1);
        end
        checks++;
        if (lat < 21 || lat > 44) begin
            errors++;
            $display("FAIL minus_latency got %0d exp 21..44", lat);
        end
        mask[7] = 1'b0;
        wait_cyc(30);
        checks++;
        if (strobes != s0 + 1) begin
            errors++;
            $display("FAIL minus_release got %0d exp 1", strobes - s0);
        end
        checks++;
        if (bus.CSseg !== 7'b1111110) begin
            errors++;
            $display("FAIL minus_seg got %b exp 1111110", bus.CSseg);
        end
        checks++;
        if (bus.pulsacion !== 4'd1) begin
            errors++;
            $display("FAIL minus_puls got %0d exp 1", bus.pulsacion);
        end
        checks++;
        if (bus.tipo !== 1'b0) begin
            errors++;
            $display("FAIL minus_tipo got %b exp 0", bus.tipo);
        end
    endtask

    task automatic test_clear();
        int s0;
        s0 = strobes;
        tap(12, 50, 30);
        checks++;
        if (strobes != s0 + 1) begin
            errors++;
            $display("FAIL clr_strobe got %0d exp 1", strobes - s0);
        end
        checks++;
        if (bus.pulsacion !== 4'd0) begin
            errors++;
            $display("FAIL clr_puls got %0d exp 0", bus.pulsacion);
        end
        checks++;
        if (bus.CSseg !== 7'b1111111) begin
            errors++;
            $display("FAIL clr_seg got %b exp 1111111", bus.CSseg);
        end
        checks++;
        if (bus.tipo !== 1'b0) begin
            errors++;
            $display("FAIL clr_tipo got %b exp 0", bus.tipo);
        end
    endtask

    task automatic test_full_entry();
        int keys [9] = '{3, 0, 1, 2, 7, 4, 5, 6, 11};
        logic [6:0] segs [9] = '{
            7'b1101100, 7'b1001111, 7'b0010010,
            7'b0000110, 7'b1111110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b1110110
        };
        logic tps [9] = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
        int s0;
        logic [3:0] ep;
        for (int i = 0; i < 9; i++) begin
            s0 = strobes;
            ep = (i < 8) ? 4'(i + 1) : 4'd8;
            tap(keys[i], 50, 30);
            checks++;
            if (strobes != s0 + 1) begin
                errors++;
                $display("FAIL entry%0d_strobe got %0d exp 1",
                         i, strobes - s0);
            end
            checks++;
            if (bus.pulsacion !== ep) begin
                errors++;
                $display("FAIL entry%0d_puls got %0d exp %0d",
                         i, bus.pulsacion, ep);
            end
            checks++;
            if (bus.tipo !== tps[i]) begin
                errors++;
                $display("FAIL entry%0d_tipo got %b exp %b",
                         i, bus.tipo, tps[i]);
            end
            checks++;
            if (bus.CSseg !== segs[i]) begin
                errors++;
                $display("FAIL entry%0d_seg got %b exp %b",
                         i, bus.CSseg, segs[i]);
            end
        end
        s0 = strobes;
        tap(8, 50, 30);
        checks++;
        if (strobes != s0) begin
            errors++;
            $display("FAIL done_ignore got %0d exp 0", strobes - s0);
        end
        checks++;
        if (bus.CSseg !== 7'b1110110 || bus.pulsacion !== 4'd8) begin
            errors++;
            $display("FAIL done_hold got %b/%0d exp 1110110/8",
                     bus.CSseg, bus.pulsacion);
        end
    endtask

    task automatic test_grammar();
        int s0;
        s0 = strobes;
        tap(11, 50, 30);
        tap(10, 50, 30);
        checks++;
        if (strobes != s0) begin
            errors++;
            $display("FAIL gram_p0 got %0d exp 0", strobes - s0);
        end
        checks++;
        if (bus.pulsacion !== 4'd0) begin
            errors++;
            $display("FAIL gram_p0_puls got %0d exp 0", bus.pulsacion);
        end
        tap(3, 50, 30);
        tap(0, 50, 30);
        tap(1, 50, 30);
        checks++;
        if (bus.pulsacion !== 4'd3) begin
            errors++;
            $display("FAIL gram_p3 got %0d exp 3", bus.pulsacion);
        end
        s0 = strobes;
        tap(3, 50, 30);
        checks++;
        if (strobes != s0 || bus.pulsacion !== 4'd3) begin
            errors++;
            $display("FAIL gram_op_rej strobes %0d puls %0d exp 0 3",
                     strobes - s0, bus.pulsacion);
        end
        test_clear();
    endtask

    task automatic test_bounce();
        int s0;
        tap(3, 50, 30);
        s0 = strobes;
        for (int i = 0; i < 5; i++) begin
            mask[5] = ~mask[5];
            wait_cyc(3);
        end
        wait_cyc(45);
        checks++;
        if (strobes != s0 + 1) begin
            errors++;
            $display("FAIL bounce_strobe got %0d exp 1", strobes - s0);
        end
        checks++;
        if (bus.CSseg !== 7'b0100100) begin
            errors++;
            $display("FAIL bounce_seg got %b exp 0100100", bus.CSseg);
        end
        checks++;
        if (bus.pulsacion !== 4'd2 || bus.tipo !== 1'b1) begin
            errors++;
            $display("FAIL bounce_puls got %0d/%b exp 2/1",
                     bus.pulsacion, bus.tipo);
        end
        for (int i = 0; i < 5; i++) begin
            mask[5] = ~mask[5];
            wait_cyc(3);
        end
        wait_cyc(30);
        checks++;
        if (strobes != s0 + 1) begin
            errors++;
            $display("FAIL bounce_release got %0d exp 1", strobes - s0);
        end
    endtask

    task automatic test_ghost();
        int s0;
        s0 = strobes;
        mask[4] = 1'b1;
        mask[8] = 1'b1;
        wait_cyc(50);
        mask = 16'h0;
        wait_cyc(30);
        checks++;
        if (strobes != s0) begin
            errors++;
            $display("FAIL ghost_strobe got %0d exp 0", strobes - s0);
        end
        checks++;
        if (bus.pulsacion !== 4'd2) begin
            errors++;
            $display("FAIL ghost_puls got %0d exp 2", bus.pulsacion);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        s0 = strobes;
        mask[6] = 1'b1;
        wait_cyc(18);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.columnas !== 4'b1110) begin
            errors++;
            $display("FAIL rmid_col got %b exp 1110", bus.columnas);
        end
        checks++;
        if (bus.CSseg !== 7'b1111111 || bus.tipo !== 1'b0) begin
            errors++;
            $display("FAIL rmid_seg got %b/%b exp 1111111/0",
                     bus.CSseg, bus.tipo);
        end
        checks++;
        if (bus.pulsacion !== 4'd0 || bus.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_puls got %0d/%b exp 0/0",
                     bus.pulsacion, bus.key_valid);
        end
        mask = 16'h0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(40);
        checks++;
        if (strobes != s0) begin
            errors++;
            $display("FAIL rmid_strobe got %0d exp 0", strobes - s0);
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (doubles != 0) begin
            errors++;
            $display("FAIL kv_double got %0d exp 0", doubles);
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_clear();
        test_full_entry();
        test_clear();
        test_grammar();
        test_bounce();
        test_ghost();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
